udp_tx_arbiter: RTL and testbench
=================================

UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of UDP TX input channels (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 512: payload beat width. KEEP_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter CONN_ID_WIDTH, default 18: connection-id width (HASH_WIDTH 16 + log2 WAYS 4).
REQ-004 SHALL have parameter CNT_WIDTH, default 32: width of the statistics counters.
REQ-005 SHALL use one clock and one reset: the clock is tx_axis_aclk and the reset is tx_axis_areset, which is asynchronous and active-high.
REQ-006 Ports (in = input, out = output):
  tx_axis_aclk  in  1  clock
  tx_axis_areset  in  1  async active-high reset
  s_udp_tvalid  in  NUM_CH  per-channel beat valid
  s_udp_tready  out  NUM_CH  per-channel beat ready
  s_udp_tlast  in  NUM_CH  per-channel end of packet
  s_udp_tdata  in  NUM_CH*DATA_WIDTH  payload, channel i at slice i
  s_udp_tkeep  in  NUM_CH*KEEP_WIDTH  byte enables
  s_udp_connection_id  in  NUM_CH*CONN_ID_WIDTH  connection id, sampled on first beat only
  m01_axis_rv_lookup_valid  out  1  reverse-lookup request valid
  m01_axis_rv_lookup_connectionId  out  CONN_ID_WIDTH  request id
  m01_axis_rv_lookup_ready  in  1  request accepted
  s01_axis_rv_lookup_valid  in  1  response valid
  s01_axis_rv_lookup_ready  out  1  response ready
  s01_axis_rv_lookup_hit  in  1  entry found
  s01_axis_rv_lookup_macAddr  in  48  destination MAC
  s01_axis_rv_lookup_ipAddr  in  32  destination IP
  s01_axis_rv_lookup_udpPort  in  16  destination UDP port
  m_udp_tvalid  out  1  output beat valid
  m_udp_tready  in  1  downstream ready
  m_udp_tlast  out  1  output end of packet
  m_udp_tdata  out  DATA_WIDTH  payload
  m_udp_tkeep  out  KEEP_WIDTH  byte enables
  m_udp_macAddr / m_udp_ipAddr / m_udp_udpPort  out  48/32/16  resolved destination, stable for whole packet
  m_udp_channel  out  clog2(NUM_CH)  source channel of current packet
  stat_fwd_pkts  out  CNT_WIDTH  packets forwarded
  stat_drop_pkts  out  CNT_WIDTH  packets dropped on lookup miss

Function
REQ-007 SHALL implement FSM states IDLE, LOOKUP_REQ, LOOKUP_RESP, FORWARD, DROP.
REQ-008 IDLE: if any s_udp_tvalid is high, SHALL grant the first valid channel at or after rr_ptr (wrapping modulo NUM_CH), latch its channel index and connection_id, and go to LOOKUP_REQ next cycle. No beat is consumed in IDLE.
REQ-009 LOOKUP_REQ: SHALL hold m01_axis_rv_lookup_valid=1 with the latched id, stable until m01_axis_rv_lookup_ready=1, then go to LOOKUP_RESP.
REQ-010 LOOKUP_RESP: SHALL drive s01_axis_rv_lookup_ready=1. On response valid with hit=1, SHALL latch mac/ip/port and go to FORWARD. On hit=0, SHALL go to DROP.
REQ-011 FORWARD: m_udp_tvalid/tdata/tkeep/tlast SHALL combinationally mirror the granted channel. Granted s_udp_tready SHALL equal m_udp_tready. All other s_udp_tready SHALL be 0.
REQ-012 DROP: granted s_udp_tready SHALL be 1 and m_udp_tvalid SHALL be 0; beats are discarded.
REQ-013 On a handshaken beat with tlast=1 in FORWARD or DROP:
  - SHALL increment stat_fwd_pkts (FORWARD) or stat_drop_pkts (DROP);
  - SHALL set rr_ptr = granted+1 mod NUM_CH;
  - SHALL return to IDLE.
REQ-014 Minimum overhead SHALL be 3 cycles (IDLE, LOOKUP_REQ, LOOKUP_RESP) per packet when lookup ready and response arrive the same cycle they are awaited; first output beat appears in the 4th cycle.
REQ-015 Counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-016 A single-beat packet (tlast on first beat) SHALL be handled as a complete packet.
REQ-017 Input valid deasserting mid-packet SHALL stall without regrant; the arbiter SHALL never switch channels before tlast.
REQ-018 A response arriving while not in LOOKUP_RESP SHALL be ignored (ready=0).
REQ-019 m_udp_macAddr/ipAddr/udpPort/channel SHALL hold their latched values until the next lookup response is accepted.

Reset
REQ-020 While tx_axis_areset=1, all of the following SHALL be 0 immediately:
  - FSM = IDLE, rr_ptr = 0;
  - all s_udp_tready, m01_axis_rv_lookup_valid, s01_axis_rv_lookup_ready;
  - m_udp_tvalid, m_udp_tlast, latched destination fields, m_udp_channel;
  - both counters.
REQ-021 Reset mid-packet SHALL abandon the packet. After release, the FSM SHALL restart from IDLE without counting it.

Verification
REQ-022 Scenario: ch0 sends 3-beat packet, id 0x00005, lookup hit mac 0x0A0B0C0D0E0F -> 3 beats out with macAddr 0x0A0B0C0D0E0F, m_udp_channel=0, stat_fwd_pkts=1.
REQ-023 Scenario: all 4 channels valid continuously with 1-beat packets -> grants in order 0,1,2,3,0, no channel repeats before others are served.
REQ-024 Scenario: ch2 lookup miss on a 4-beat packet -> ch2 tready=1 for 4 beats, m_udp_tvalid stays 0, stat_drop_pkts=1, next grant goes to ch3.
REQ-025 Scenario: m01_axis_rv_lookup_ready held 0 for 5 cycles -> request valid and id stay stable for 5 cycles, no input beat consumed.
REQ-026 Scenario: m_udp_tready toggles 1,0,1,0 during FORWARD -> no beat lost or duplicated; ch1 stays granted even though ch0 is valid.
REQ-027 Scenario: assert reset during beat 2 of a 4-beat packet -> outputs 0 immediately, counters 0, next packet on ch0 served normally.

Source files
------------

// File: rtl/udp_tx_arbiter_if.sv
// udp_tx_arbiter_if: channel inputs, reverse-lookup request/response and merged UDP output bundle
interface udp_tx_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = 512,
  parameter int CONN_ID_WIDTH = 18,
  parameter int CNT_WIDTH = 32
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int CH_W = $clog2(NUM_CH);
  logic [NUM_CH-1:0] s_udp_tvalid;
  logic [NUM_CH-1:0] s_udp_tready;
  logic [NUM_CH-1:0] s_udp_tlast;
  logic [NUM_CH*DATA_WIDTH-1:0] s_udp_tdata;
  logic [NUM_CH*KEEP_WIDTH-1:0] s_udp_tkeep;
  logic [NUM_CH*CONN_ID_WIDTH-1:0] s_udp_connection_id;
  logic m01_axis_rv_lookup_valid;
  logic [CONN_ID_WIDTH-1:0] m01_axis_rv_lookup_connectionId;
  logic m01_axis_rv_lookup_ready;
  logic s01_axis_rv_lookup_valid;
  logic s01_axis_rv_lookup_ready;
  logic s01_axis_rv_lookup_hit;
  logic [47:0] s01_axis_rv_lookup_macAddr;
  logic [31:0] s01_axis_rv_lookup_ipAddr;
  logic [15:0] s01_axis_rv_lookup_udpPort;
  logic m_udp_tvalid;
  logic m_udp_tready;
  logic m_udp_tlast;
  logic [DATA_WIDTH-1:0] m_udp_tdata;
  logic [KEEP_WIDTH-1:0] m_udp_tkeep;
  logic [47:0] m_udp_macAddr;
  logic [31:0] m_udp_ipAddr;
  logic [15:0] m_udp_udpPort;
  logic [CH_W-1:0] m_udp_channel;
  logic [CNT_WIDTH-1:0] stat_fwd_pkts;
  logic [CNT_WIDTH-1:0] stat_drop_pkts;
  modport slave (
    input s_udp_tvalid, s_udp_tlast, s_udp_tdata, s_udp_tkeep, s_udp_connection_id,
    input m01_axis_rv_lookup_ready, s01_axis_rv_lookup_valid, s01_axis_rv_lookup_hit,
    input s01_axis_rv_lookup_macAddr, s01_axis_rv_lookup_ipAddr, s01_axis_rv_lookup_udpPort, m_udp_tready,
    output s_udp_tready, m01_axis_rv_lookup_valid, m01_axis_rv_lookup_connectionId, s01_axis_rv_lookup_ready,
    output m_udp_tvalid, m_udp_tlast, m_udp_tdata, m_udp_tkeep, m_udp_macAddr, m_udp_ipAddr, m_udp_udpPort,
    output m_udp_channel, stat_fwd_pkts, stat_drop_pkts
  );
  modport master (
    output s_udp_tvalid, s_udp_tlast, s_udp_tdata, s_udp_tkeep, s_udp_connection_id,
    output m01_axis_rv_lookup_ready, s01_axis_rv_lookup_valid, s01_axis_rv_lookup_hit,
    output s01_axis_rv_lookup_macAddr, s01_axis_rv_lookup_ipAddr, s01_axis_rv_lookup_udpPort, m_udp_tready,
    input s_udp_tready, m01_axis_rv_lookup_valid, m01_axis_rv_lookup_connectionId, s01_axis_rv_lookup_ready,
    input m_udp_tvalid, m_udp_tlast, m_udp_tdata, m_udp_tkeep, m_udp_macAddr, m_udp_ipAddr, m_udp_udpPort,
    input m_udp_channel, stat_fwd_pkts, stat_drop_pkts
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin packet arbiter that resolves each packet's destination via reverse lookup
module udp_tx_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_WIDTH = 512,
  parameter int CONN_ID_WIDTH = 18,
  parameter int CNT_WIDTH = 32
) (
  input logic tx_axis_aclk,
  input logic tx_axis_areset,
  udp_tx_arbiter_if.slave bus
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int CH_W = $clog2(NUM_CH);
  typedef enum logic [2:0] {IDLE, LOOKUP_REQ, LOOKUP_RESP, FORWARD, DROP} state_t;
  state_t state_q, state_d;
  logic [CH_W-1:0] rr_q, rr_d, gnt_q, gnt_d, chan_q, chan_d, pick, idx;
  logic [CONN_ID_WIDTH-1:0] id_q, id_d;
  logic [47:0] mac_q, mac_d;
  logic [31:0] ip_q, ip_d;
  logic [15:0] port_q, port_d;
  logic [CNT_WIDTH-1:0] fwd_q, fwd_d, drop_q, drop_d;
  logic found, sel_valid, sel_last, sel_ready, pkt_end, resp_hit;
  always_comb begin
    found = 1'b0;
    pick = rr_q;
    idx = rr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((int'(rr_q) + i) % NUM_CH);
      if (!found && bus.s_udp_tvalid[idx]) begin
        found = 1'b1;
        pick = idx;
      end
    end
  end
  assign sel_valid = bus.s_udp_tvalid[gnt_q];
  assign sel_last = bus.s_udp_tlast[gnt_q];
  assign sel_ready = state_q == FORWARD ? bus.m_udp_tready : state_q == DROP;
  assign pkt_end = sel_valid && sel_ready && sel_last;
  assign resp_hit = state_q == LOOKUP_RESP && bus.s01_axis_rv_lookup_valid && bus.s01_axis_rv_lookup_hit;
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    id_d = id_q;
    rr_d = rr_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = LOOKUP_REQ;
        gnt_d = pick;
        id_d = bus.s_udp_connection_id[int'(pick)*CONN_ID_WIDTH +: CONN_ID_WIDTH];
      end
      LOOKUP_REQ: state_d = bus.m01_axis_rv_lookup_ready ? LOOKUP_RESP : LOOKUP_REQ;
      LOOKUP_RESP: if (bus.s01_axis_rv_lookup_valid) state_d = bus.s01_axis_rv_lookup_hit ? FORWARD : DROP;
      FORWARD, DROP: if (pkt_end) begin
        state_d = IDLE;
        rr_d = CH_W'((int'(gnt_q) + 1) % NUM_CH);
      end
      default: state_d = IDLE;
    endcase
  end
  // the output channel tag follows every accepted response; the destination only follows hits
  assign chan_d = state_q == LOOKUP_RESP && bus.s01_axis_rv_lookup_valid ? gnt_q : chan_q;
  assign mac_d = resp_hit ? bus.s01_axis_rv_lookup_macAddr : mac_q;
  assign ip_d = resp_hit ? bus.s01_axis_rv_lookup_ipAddr : ip_q;
  assign port_d = resp_hit ? bus.s01_axis_rv_lookup_udpPort : port_q;
  assign fwd_d = fwd_q + CNT_WIDTH'(pkt_end && state_q == FORWARD);
  assign drop_d = drop_q + CNT_WIDTH'(pkt_end && state_q == DROP);
  always_ff @(posedge tx_axis_aclk or posedge tx_axis_areset) begin
    if (tx_axis_areset) begin
      state_q <= IDLE;
      rr_q <= '0;
      gnt_q <= '0;
      chan_q <= '0;
      id_q <= '0;
      mac_q <= '0;
      ip_q <= '0;
      port_q <= '0;
      fwd_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      chan_q <= chan_d;
      id_q <= id_d;
      mac_q <= mac_d;
      ip_q <= ip_d;
      port_q <= port_d;
      fwd_q <= fwd_d;
      drop_q <= drop_d;
    end
  end
  assign bus.s_udp_tready = sel_ready ? NUM_CH'(1) << gnt_q : '0;
  assign bus.m01_axis_rv_lookup_valid = state_q == LOOKUP_REQ;
  assign bus.m01_axis_rv_lookup_connectionId = id_q;
  assign bus.s01_axis_rv_lookup_ready = state_q == LOOKUP_RESP;
  assign bus.m_udp_tvalid = state_q == FORWARD && sel_valid;
  assign bus.m_udp_tlast = state_q == FORWARD && sel_last;
  assign bus.m_udp_tdata = bus.s_udp_tdata[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.m_udp_tkeep = bus.s_udp_tkeep[int'(gnt_q)*KEEP_WIDTH +: KEEP_WIDTH];
  assign bus.m_udp_macAddr = mac_q;
  assign bus.m_udp_ipAddr = ip_q;
  assign bus.m_udp_udpPort = port_q;
  assign bus.m_udp_channel = chan_q;
  assign bus.stat_fwd_pkts = fwd_q;
  assign bus.stat_drop_pkts = drop_q;
endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: directed packets per channel, scoreboard of expected output beats checked by a monitor
module tb_udp_tx_arbiter;
  localparam int NC = 4, DW = 32, KW = DW / 8, IW = 18, CW = 32;
  typedef struct {
    logic [1:0] ch;
    logic last;
    logic [DW-1:0] data;
    logic [47:0] mac;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lk_ready = 1'b1;
  logic tog = 1'b0;
  int tests = 0;
  int fails = 0;
  int hs_cnt [NC];
  logic [DW:0] srcq [NC][$];
  exp_t sb [$];
  exp_t e;
  always #5 clk = ~clk;
  udp_tx_arbiter_if #(.NUM_CH(NC), .DATA_WIDTH(DW), .CONN_ID_WIDTH(IW), .CNT_WIDTH(CW)) bus ();
  udp_tx_arbiter #(.NUM_CH(NC), .DATA_WIDTH(DW), .CONN_ID_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .tx_axis_aclk(clk),
    .tx_axis_areset(rst),
    .bus(bus)
  );
  function automatic logic [47:0] dest_mac(input logic [IW-1:0] id);
    return id == 18'd5 ? 48'h0A0B0C0D0E0F : {30'h1234, id};
  endfunction
  // lookup service: responds at once, ids with the top bit set are misses
  assign bus.m01_axis_rv_lookup_ready = lk_ready;
  assign bus.s01_axis_rv_lookup_valid = 1'b1;
  assign bus.s01_axis_rv_lookup_hit = !bus.m01_axis_rv_lookup_connectionId[IW-1];
  assign bus.s01_axis_rv_lookup_macAddr = dest_mac(bus.m01_axis_rv_lookup_connectionId);
  assign bus.s01_axis_rv_lookup_ipAddr = {14'h0, bus.m01_axis_rv_lookup_connectionId};
  assign bus.s01_axis_rv_lookup_udpPort = bus.m01_axis_rv_lookup_connectionId[15:0];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask
  task automatic send(input int c, input logic [IW-1:0] id, input int n, input logic [DW-1:0] base);
    bus.s_udp_connection_id[c*IW +: IW] = id;
    for (int k = 0; k < n; k++) begin
      srcq[c].push_back({k == n - 1, base + DW'(k)});
      if (!id[IW-1]) sb.push_back('{ch: 2'(c), last: k == n - 1, data: base + DW'(k), mac: dest_mac(id)});
    end
  endtask
  function automatic bit busy();
    for (int c = 0; c < NC; c++) if (srcq[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic wait_done(input string n);
    int t = 0;
    while ((sb.size() > 0 || busy()) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk({n, "_done_in_time"}, 64'(t < 500), 64'd1);
    repeat (2) @(negedge clk);
  endtask
  task automatic clear_all();
    for (int c = 0; c < NC; c++) srcq[c].delete();
    sb.delete();
  endtask
  initial begin
    logic [NC-1:0] hs;
    for (int c = 0; c < NC; c++) hs_cnt[c] = 0;
    bus.s_udp_tvalid = '0;
    bus.s_udp_tlast = '0;
    bus.s_udp_tdata = '0;
    bus.s_udp_tkeep = '0;
    bus.s_udp_connection_id = '0;
    bus.m_udp_tready = 1'b1;
    forever begin
      @(negedge clk);
      hs = bus.s_udp_tvalid & bus.s_udp_tready;
      @(posedge clk);
      #1;
      for (int c = 0; c < NC; c++) begin
        if (hs[c] && srcq[c].size() > 0) begin
          void'(srcq[c].pop_front());
          hs_cnt[c]++;
        end
        bus.s_udp_tvalid[c] = srcq[c].size() > 0;
        if (srcq[c].size() > 0) begin
          bus.s_udp_tdata[c*DW +: DW] = srcq[c][0][DW-1:0];
          bus.s_udp_tkeep[c*KW +: KW] = srcq[c][0][KW-1:0];
          bus.s_udp_tlast[c] = srcq[c][0][DW];
        end
      end
      bus.m_udp_tready = tog ? ~bus.m_udp_tready : 1'b1;
    end
  end
  always @(negedge clk) begin
    if (!rst && bus.m_udp_tvalid && bus.m_udp_tready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got data %0h on ch %0d, expected no beat", bus.m_udp_tdata, bus.m_udp_channel);
      end else begin
        e = sb.pop_front();
        chk("beat_data", 64'(bus.m_udp_tdata), 64'(e.data));
        chk("beat_keep", 64'(bus.m_udp_tkeep), 64'(e.data[KW-1:0]));
        chk("beat_last", 64'(bus.m_udp_tlast), 64'(e.last));
        chk("beat_channel", 64'(bus.m_udp_channel), 64'(e.ch));
        chk("beat_mac", 64'(bus.m_udp_macAddr), 64'(e.mac));
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int cyc;
    int base;
    repeat (3) @(negedge clk);
    chk("rst_s_tready", 64'(bus.s_udp_tready), 64'd0);
    chk("rst_req_valid", 64'(bus.m01_axis_rv_lookup_valid), 64'd0);
    chk("rst_resp_ready", 64'(bus.s01_axis_rv_lookup_ready), 64'd0);
    chk("rst_m_tvalid", 64'(bus.m_udp_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(bus.m_udp_tlast), 64'd0);
    chk("rst_mac", 64'(bus.m_udp_macAddr), 64'd0);
    chk("rst_channel", 64'(bus.m_udp_channel), 64'd0);
    chk("rst_fwd", 64'(bus.stat_fwd_pkts), 64'd0);
    chk("rst_drop", 64'(bus.stat_drop_pkts), 64'd0);
    rst = 1'b0;
    // 3-beat packet on ch0, first output beat in the 4th cycle
    @(negedge clk);
    send(0, 18'd5, 3, 32'h100);
    cyc = 0;
    while (!bus.m_udp_tvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("a_latency", 64'(cyc), 64'd4);
    wait_done("a");
    chk("a_fwd", 64'(bus.stat_fwd_pkts), 64'd1);
    chk("a_mac", 64'(bus.m_udp_macAddr), 64'h0A0B0C0D0E0F);
    chk("a_ip", 64'(bus.m_udp_ipAddr), 64'd5);
    chk("a_channel", 64'(bus.m_udp_channel), 64'd0);
    chk("a_drop", 64'(bus.stat_drop_pkts), 64'd0);
    // round robin from a fresh pointer: 0,1,2,3,0
    rst = 1'b1;
    clear_all();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(0, 18'h10, 1, 32'h200);
    send(1, 18'h11, 1, 32'h210);
    send(2, 18'h12, 1, 32'h220);
    send(3, 18'h13, 1, 32'h230);
    send(0, 18'h10, 1, 32'h240);
    wait_done("b");
    chk("b_fwd", 64'(bus.stat_fwd_pkts), 64'd5);
    // ch2 miss on 4 beats is drained, then ch3 and ch0 follow
    @(negedge clk);
    base = hs_cnt[2];
    send(2, 18'h20002, 4, 32'h300);
    send(3, 18'h13, 1, 32'h310);
    send(0, 18'h10, 1, 32'h320);
    wait_done("c");
    chk("c_drop", 64'(bus.stat_drop_pkts), 64'd1);
    chk("c_fwd", 64'(bus.stat_fwd_pkts), 64'd7);
    chk("c_drop_beats", 64'(hs_cnt[2] - base), 64'd4);
    // lookup request stalled for 5 cycles
    @(negedge clk);
    lk_ready = 1'b0;
    base = hs_cnt[1];
    send(1, 18'h33, 2, 32'h400);
    cyc = 0;
    while (!bus.m01_axis_rv_lookup_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    for (int k = 0; k < 5; k++) begin
      chk("d_req_valid", 64'(bus.m01_axis_rv_lookup_valid), 64'd1);
      chk("d_req_id", 64'(bus.m01_axis_rv_lookup_connectionId), 64'h33);
      @(negedge clk);
    end
    chk("d_no_beat_taken", 64'(hs_cnt[1] - base), 64'd0);
    lk_ready = 1'b1;
    wait_done("d");
    chk("d_fwd", 64'(bus.stat_fwd_pkts), 64'd8);
    // downstream ready toggling; ch0 arrives after ch1 is granted and must wait
    tog = 1'b1;
    @(negedge clk);
    send(1, 18'h21, 4, 32'h500);
    cyc = 0;
    while (!bus.m01_axis_rv_lookup_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    send(0, 18'h10, 1, 32'h510);
    wait_done("e");
    tog = 1'b0;
    chk("e_fwd", 64'(bus.stat_fwd_pkts), 64'd10);
    // reset during beat 2 of a 4-beat ch3 packet
    @(negedge clk);
    base = hs_cnt[3];
    send(3, 18'h13, 4, 32'h600);
    cyc = 0;
    while (hs_cnt[3] - base < 1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("f_first_beat", 64'(hs_cnt[3] - base), 64'd1);
    rst = 1'b1;
    clear_all();
    #1;
    chk("f_m_tvalid", 64'(bus.m_udp_tvalid), 64'd0);
    chk("f_s_tready", 64'(bus.s_udp_tready), 64'd0);
    chk("f_req_valid", 64'(bus.m01_axis_rv_lookup_valid), 64'd0);
    chk("f_fwd", 64'(bus.stat_fwd_pkts), 64'd0);
    chk("f_drop", 64'(bus.stat_drop_pkts), 64'd0);
    chk("f_mac", 64'(bus.m_udp_macAddr), 64'd0);
    chk("f_channel", 64'(bus.m_udp_channel), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(0, 18'd5, 2, 32'h700);
    wait_done("f");
    chk("f_fwd_after", 64'(bus.stat_fwd_pkts), 64'd1);
    chk("f_mac_after", 64'(bus.m_udp_macAddr), 64'h0A0B0C0D0E0F);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
